// File: rtl/radar_chirp_ctrl.sv
// Chirp/frame timing engine: arms on a qualified fpga_en, then issues chirp triggers, frame
// markers and the ADC capture gate. Optional frame counter output when RADAR_FRAME_CNT_EN is defined.
module radar_chirp_ctrl #(
    parameter int unsigned ARM_DELAY        = 20000,
    parameter int unsigned CHIRP_PERIOD     = 2000,
    parameter int unsigned CHIRPS_PER_FRAME = 128,
    parameter int unsigned ADC_DELAY        = 100,
    parameter int unsigned ADC_LEN          = 1600,
    parameter int unsigned FRAME_GAP        = 200000
) (
    input  logic        clk_200m,
    input  logic        rst,
    input  logic        init_en,
    input  logic        fpga_en,
    output logic        chirp_trig,
    output logic        frame_start,
    output logic        frame_done,
    output logic        adc_gate,
    output logic [7:0]  chirp_idx,
`ifdef RADAR_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        busy
);

    localparam int unsigned ArmW   = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam int unsigned PhaseW = (CHIRP_PERIOD > 1) ? $clog2(CHIRP_PERIOD) : 1;
    localparam int unsigned IdxW   = (CHIRPS_PER_FRAME > 1) ? $clog2(CHIRPS_PER_FRAME) : 1;
    localparam int unsigned GapW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [ArmW-1:0]   ArmLast   = ArmW'(ARM_DELAY - 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CHIRP_PERIOD - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(CHIRPS_PER_FRAME - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(FRAME_GAP - 1);
    localparam logic [PhaseW-1:0] AdcStart  = PhaseW'(ADC_DELAY);
    localparam logic [PhaseW-1:0] AdcEnd    = PhaseW'(ADC_DELAY + ADC_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StChirp,
        StGap
    } state_e;

    state_e              state_q, state_d;
    logic [ArmW-1:0]     arm_q, arm_d;
    logic [PhaseW-1:0]   phase_q, phase_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [GapW-1:0]     gap_q, gap_d;
    // Latches an fpga_en drop so the running chirp finishes and the frame then stops.
    logic                stop_q, stop_d;

    logic                trig_d;
    logic                fstart_d;
    logic                fdone_d;
    logic                adc_d;
    logic                busy_d;
    logic                in_chirp_d;

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        stop_d  = stop_q;

        if (init_en) begin
            state_d = StIdle;
            arm_d   = '0;
            phase_d = '0;
            idx_d   = '0;
            gap_d   = '0;
            stop_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    arm_d   = '0;
                    phase_d = '0;
                    idx_d   = '0;
                    gap_d   = '0;
                    stop_d  = 1'b0;
                    if (fpga_en) begin
                        state_d = StArm;
                    end
                end

                StArm: begin
                    if (!fpga_en) begin
                        state_d = StIdle;
                        arm_d   = '0;
                    end else if (arm_q == ArmLast) begin
                        state_d = StChirp;
                        arm_d   = '0;
                        phase_d = '0;
                        idx_d   = '0;
                        stop_d  = 1'b0;
                    end else begin
                        arm_d = arm_q + ArmW'(1);
                    end
                end

                StChirp: begin
                    stop_d = stop_q | ~fpga_en;
                    if (phase_q == PhaseLast) begin
                        phase_d = '0;
                        if (stop_d) begin
                            state_d = StIdle;
                            idx_d   = '0;
                            stop_d  = 1'b0;
                        end else if (idx_q == IdxLast) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PhaseW'(1);
                    end
                end

                StGap: begin
                    if (gap_q == GapLast) begin
                        gap_d   = '0;
                        idx_d   = '0;
                        phase_d = '0;
                        state_d = fpga_en ? StChirp : StIdle;
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values and registered, so they line up with state_q.
    always_comb begin
        in_chirp_d = (state_d == StChirp);
        trig_d     = in_chirp_d && (phase_d == '0);
        fstart_d   = trig_d && (idx_d == '0);
        fdone_d    = in_chirp_d && (phase_d == PhaseLast) && (idx_d == IdxLast) && !stop_d;
        adc_d      = in_chirp_d && (phase_d >= AdcStart) && (phase_d < AdcEnd);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk_200m) begin
        if (rst) begin
            state_q     <= StIdle;
            arm_q       <= '0;
            phase_q     <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            stop_q      <= 1'b0;
            chirp_trig  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            adc_gate    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            stop_q      <= stop_d;
            chirp_trig  <= trig_d;
            frame_start <= fstart_d;
            frame_done  <= fdone_d;
            adc_gate    <= adc_d;
            busy        <= busy_d;
        end
    end

    assign chirp_idx = 8'(idx_q);

`ifdef RADAR_FRAME_CNT_EN
    // Survives IDLE and init_en; only rst clears it.
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_radar_chirp_ctrl.sv
// Self-checking bench for radar_chirp_ctrl: directed scenarios plus random stimulus checked
// against a frame-time reference model. Frame counter checks follow RADAR_FRAME_CNT_EN.
`timescale 1ns/100ps
module tb_radar_chirp_ctrl;

    localparam int AD       = 8;
    localparam int CP       = 20;
    localparam int CPF      = 4;
    localparam int AdcD     = 3;
    localparam int AdcL     = 10;
    localparam int FG       = 15;
    localparam int FrameLen = CPF * CP;
    localparam int PerLen   = FrameLen + FG;

    logic        clk_200m = 1'b0;
    logic        rst      = 1'b1;
    logic        init_en  = 1'b0;
    logic        fpga_en  = 1'b0;
    logic        chirp_trig;
    logic        frame_start;
    logic        frame_done;
    logic        adc_gate;
    logic [7:0]  chirp_idx;
    logic        busy;
`ifdef RADAR_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #2.5 clk_200m = ~clk_200m;

    radar_chirp_ctrl #(
        .ARM_DELAY        (AD),
        .CHIRP_PERIOD     (CP),
        .CHIRPS_PER_FRAME (CPF),
        .ADC_DELAY        (AdcD),
        .ADC_LEN          (AdcL),
        .FRAME_GAP        (FG)
    ) dut (
        .clk_200m    (clk_200m),
        .rst         (rst),
        .init_en     (init_en),
        .fpga_en     (fpga_en),
        .chirp_trig  (chirp_trig),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .adc_gate    (adc_gate),
        .chirp_idx   (chirp_idx),
`ifdef RADAR_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .busy        (busy)
    );

    logic [12:0] act_vec;
    assign act_vec = {chirp_trig, frame_start, frame_done, adc_gate, busy, chirp_idx};

    // Reference model: mode + time within the frame period (t), outputs by arithmetic on t.
    int          m_mode = 0;  // 0 idle, 1 arming, 2 running
    int          m_arm  = 0;  // qualified samples seen while arming
    int          m_t    = 0;
    bit          m_stop = 1'b0;
    logic [15:0] m_fcnt = '0;
    logic        e_fd   = 1'b0;
    logic [12:0] exp_vec = '0;

    task automatic go_idle();
        m_mode = 0;
        m_arm  = 0;
        m_t    = 0;
        m_stop = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit i, input bit f);
        bit   qual;
        bit   in_chirp;
        int   ph;
        int   idx;
        logic e_trig, e_fs, e_adc, e_busy;
        qual = f && !i;
        if (e_fd) m_fcnt = m_fcnt + 16'd1;
        if (r) begin
            go_idle();
            m_fcnt = '0;
        end else if (i) begin
            go_idle();
        end else begin
            case (m_mode)
                0: if (qual) begin
                    m_mode = 1;
                    m_arm  = 1;
                end
                1: if (!qual) go_idle();
                   else if (m_arm == AD) begin
                       m_mode = 2;
                       m_t    = 0;
                       m_stop = 1'b0;
                   end else m_arm++;
                default: begin
                    if (m_t < FrameLen) begin
                        if (!f) m_stop = 1'b1;
                        if ((m_t % CP) == CP - 1 && m_stop) go_idle();
                        else m_t++;
                    end else if (m_t == PerLen - 1) begin
                        if (qual) m_t = 0;
                        else go_idle();
                    end else m_t++;
                end
            endcase
        end
        in_chirp = (m_mode == 2) && (m_t < FrameLen);
        ph       = m_t % CP;
        e_trig   = in_chirp && ph == 0;
        e_fs     = in_chirp && m_t == 0;
        e_fd     = in_chirp && m_t == FrameLen - 1 && !m_stop;
        e_adc    = in_chirp && ph >= AdcD && ph < AdcD + AdcL;
        e_busy   = (m_mode != 0);
        idx      = in_chirp ? m_t / CP : ((m_mode == 2) ? CPF - 1 : 0);
        exp_vec  = {e_trig, e_fs, e_fd, e_adc, e_busy, 8'(idx)};
    endtask

    task automatic tick(input bit r, input bit i, input bit f);
        rst     = r;
        init_en = i;
        fpga_en = f;
        @(posedge clk_200m);
        model_step(r, i, f);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 1'b1);
            checks++;
            if (act_vec !== 13'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want %h", k, act_vec, 13'd0);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if ({chirp_trig, frame_start, adc_gate, frame_done} !== {(k == 9), (k == 9), 2'b00}) begin
                errors++;
                $display("FAIL reset_release[%0d]: got trig=%b fs=%b adc=%b fd=%b want trig=fs=%b",
                         k, chirp_trig, frame_start, adc_gate, frame_done, (k == 9));
            end
        end
    endtask

    task automatic test_nominal();
        int trig_q[$];
        int fs_q[$];
        int fd_q[$];
        int rise_q[$];
        int adc_cnt;
        logic prev_adc;
        int exp_trig[5] = '{9, 29, 49, 69, 104};
        adc_cnt  = 0;
        prev_adc = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 110; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (chirp_trig) trig_q.push_back(k);
            if (frame_start) fs_q.push_back(k);
            if (frame_done) fd_q.push_back(k);
            if (adc_gate && !prev_adc) rise_q.push_back(k);
            if (adc_gate && k <= 88) adc_cnt++;
            prev_adc = adc_gate;
        end
        checks++;
        if (trig_q.size() != 5) begin
            errors++;
            $display("FAIL nom_trig_count: got %0d want 5", trig_q.size());
        end else begin
            for (int n = 0; n < 5; n++) begin
                checks++;
                if (trig_q[n] != exp_trig[n]) begin
                    errors++;
                    $display("FAIL nom_trig_time[%0d]: got %0d want %0d", n, trig_q[n], exp_trig[n]);
                end
            end
        end
        checks++;
        if (fs_q.size() != 2 || fs_q[0] != 9 || fs_q[1] != 104) begin
            errors++;
            $display("FAIL nom_frame_start: got %p want '{9, 104}", fs_q);
        end
        checks++;
        if (fd_q.size() != 1 || fd_q[0] != 9 + 79) begin
            errors++;
            $display("FAIL nom_frame_done: got %p want '{88}", fd_q);
        end
        checks++;
        if (rise_q.size() < 4) begin
            errors++;
            $display("FAIL nom_adc_rises: got %0d want >=4", rise_q.size());
        end else begin
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (rise_q[n] != exp_trig[n] + AdcD) begin
                    errors++;
                    $display("FAIL nom_adc_rise[%0d]: got %0d want %0d", n, rise_q[n],
                             exp_trig[n] + AdcD);
                end
            end
        end
        checks++;
        if (adc_cnt != 4 * AdcL) begin
            errors++;
            $display("FAIL nom_adc_width: got %0d want %0d", adc_cnt, 4 * AdcL);
        end
    endtask

    task automatic test_arm_abort();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, chirp_trig} !== 2'b00) begin
            errors++;
            $display("FAIL arm_abort_idle: got busy=%b trig=%b want 0 0", busy, chirp_trig);
        end
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if (chirp_trig !== (k == 9)) begin
                errors++;
                $display("FAIL arm_requal[%0d]: got trig=%b want %b", k, chirp_trig, (k == 9));
            end
        end
    endtask

    task automatic test_fpga_drop();
        bit found;
        int adc_cnt, trig_cnt, fd_cnt;
        found = 1'b0;
        adc_cnt = 0; trig_cnt = 0; fd_cnt = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 200 && !found; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            found = chirp_trig && chirp_idx == 8'd1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drop_wait_chirp1: got no chirp 1 trigger within 200 cycles want one");
        end
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (adc_gate) adc_cnt++;
        end
        for (int j = 1; j <= 40; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (adc_gate) adc_cnt++;
            if (chirp_trig) trig_cnt++;
            if (frame_done) fd_cnt++;
            if (j == 14) begin
                checks++;
                if ({busy, chirp_idx} !== {1'b1, 8'd1}) begin
                    errors++;
                    $display("FAIL drop_last_phase: got busy=%b idx=%0d want 1 1", busy, chirp_idx);
                end
            end
            if (j == 15) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_busy_low: got %b want 0", busy);
                end
            end
        end
        checks++;
        if (adc_cnt != AdcL || trig_cnt != 0 || fd_cnt != 0) begin
            errors++;
            $display("FAIL drop_counts: got adc=%0d trig=%0d fd=%0d want adc=%0d trig=0 fd=0",
                     adc_cnt, trig_cnt, fd_cnt, AdcL);
        end
    endtask

    task automatic test_init_abort();
        bit found;
        int bad;
`ifdef RADAR_FRAME_CNT_EN
        logic [15:0] cnt_before;
`endif
        found = 1'b0;
        bad = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 300 && !found; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            found = chirp_trig && chirp_idx == 8'd2;
        end
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (!found || adc_gate !== 1'b1) begin
            errors++;
            $display("FAIL init_setup: got found=%b adc=%b want 1 1", found, adc_gate);
        end
`ifdef RADAR_FRAME_CNT_EN
        cnt_before = frame_cnt;
`endif
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (act_vec !== 13'd0) begin
            errors++;
            $display("FAIL init_outputs_zero: got %h want %h", act_vec, 13'd0);
        end
        for (int k = 0; k < 30; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (act_vec !== 13'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_hold_idle: got %0d nonzero cycles want 0", bad);
        end
`ifdef RADAR_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== cnt_before) begin
            errors++;
            $display("FAIL init_frame_cnt: got %0d want %0d", frame_cnt, cnt_before);
        end
`endif
    endtask

`ifdef RADAR_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int n;
        n = 0;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL fcnt_reset: got %0d want 0", frame_cnt);
        end
        for (int k = 0; k < 250 && n < 2; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (frame_done) begin
                n++;
                tick(1'b0, 1'b0, 1'b1);
                checks++;
                if (frame_cnt !== 16'(n)) begin
                    errors++;
                    $display("FAIL fcnt_incr: got %0d want %0d", frame_cnt, n);
                end
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL fcnt_frames: got %0d frame_done pulses want 2", n);
        end
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL fcnt_hold: got %0d want 2", frame_cnt);
        end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL fcnt_clear: got %0d want 0", frame_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int  init_hold;
        bit  r, i, f;
        init_hold = 0;
        f = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 999) == 0);
            if (init_hold == 0 && $urandom_range(0, 199) == 0) init_hold = $urandom_range(1, 6);
            i = (init_hold > 0);
            if (init_hold > 0) init_hold--;
            if (f ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 29) == 0)) f = !f;
            tick(r, i, f);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL rand[%0d]: got {trig,fs,fd,adc,busy,idx}=%h want %h", k, act_vec,
                         exp_vec);
            end
`ifdef RADAR_FRAME_CNT_EN
            checks++;
            if (frame_cnt !== m_fcnt) begin
                errors++;
                $display("FAIL rand_fcnt[%0d]: got %0d want %0d", k, frame_cnt, m_fcnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_arm_abort();
        test_fpga_drop();
        test_init_abort();
`ifdef RADAR_FRAME_CNT_EN
        test_frame_cnt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
